// File: rtl/scmp_clk_pkg.sv
// Shared types and constants for the SC/MP clock/run controller.
package scmp_clk_pkg;

    // Controller state, also exported on the debug/LED port.
    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_HALT       = 2'd1,
        ST_RUN        = 2'd2,
        ST_STEP       = 2'd3
    } ctl_state_t;

    // Width of the SC/MP address bus seen by the breakpoint comparator.
    localparam int ADDR_W = 12;

endpackage

// File: rtl/scmp_clk_ctl_if.sv
// CPU-side bus of the clock controller: clock enable, CPU reset, status
// and the address bus used for breakpoints.
// Optional feature macro: SCMP_CLK_BREAK_EN adds bp_addr / bp_en.
interface scmp_clk_if;
    import scmp_clk_pkg::*;

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ce;
    logic              cpu_rst_n;
    logic              halted;
    ctl_state_t        state;
`ifdef SCMP_CLK_BREAK_EN
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_en;
`endif

`ifdef SCMP_CLK_BREAK_EN
    // Controller side: drives the CPU enables, watches the address bus.
    modport master (
        output cpu_ce, cpu_rst_n, halted, state,
        input  cpu_addr, bp_addr, bp_en
    );
    // CPU / board side.
    modport slave (
        input  cpu_ce, cpu_rst_n, halted, state,
        output cpu_addr, bp_addr, bp_en
    );
`else
    // Controller side: drives the CPU enables, watches the address bus.
    modport master (
        output cpu_ce, cpu_rst_n, halted, state,
        input  cpu_addr
    );
    // CPU / board side.
    modport slave (
        input  cpu_ce, cpu_rst_n, halted, state,
        output cpu_addr
    );
`endif

endinterface

// File: rtl/scmp_debounce.sv
// Button conditioner: 2-FF synchroniser, inversion of the active-low
// button, stability counter and a one-cycle event on each new press.
module scmp_debounce #(
    parameter int DB_W = 16
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_ev_o
);

    logic [1:0]      sync_q;
    logic            pressed_raw;
    logic            db_q, db_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            ev_q, ev_d;

    assign pressed_raw = ~sync_q[1];

    // Accept a new level only after it has differed from the debounced
    // level for 2**DB_W consecutive cycles; fire an event on a new press.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        ev_d  = 1'b0;
        if (pressed_raw == db_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = '0;
            db_d  = pressed_raw;
            ev_d  = pressed_raw;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset leaves the button in the "released" state.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            db_q   <= 1'b0;
            cnt_q  <= '0;
            ev_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_n_i};
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            ev_q   <= ev_d;
        end
    end

    assign press_ev_o = ev_q;

endmodule

// File: rtl/scmp_clk_ctl.sv
// Run/halt/single-step sequencer for the SC/MP core. Produces a one-cycle
// clock enable on clk_50m and a controlled CPU reset.
// Optional feature macro: SCMP_CLK_BREAK_EN (address breakpoint in RUN).
module scmp_clk_ctl
    import scmp_clk_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int DB_W         = 16,
    parameter int RST_CYC      = 16,
    parameter bit START_HALTED = 1'b0
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             run_btn_n,
    input  logic             step_btn_n,
    scmp_clk_if.master       bus
);

    localparam int HOLD_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYC - 1);

    ctl_state_t       state_q;
    logic             cpu_ce_q;
    logic             cpu_rst_n_q;
    logic             halted_q;
    logic [DIV_W-1:0] cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic             armed_q;
    logic             run_ev;
    logic             step_ev;
    logic             bp_hit;

    scmp_debounce #(.DB_W(DB_W)) u_run_db (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .btn_n_i    (run_btn_n),
        .press_ev_o (run_ev)
    );

    scmp_debounce #(.DB_W(DB_W)) u_step_db (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .btn_n_i    (step_btn_n),
        .press_ev_o (step_ev)
    );

`ifdef SCMP_CLK_BREAK_EN
    // A breakpoint only counts once the current run has delivered a CE,
    // so resuming while sitting on the breakpoint address makes progress.
    assign bp_hit = bus.bp_en && (bus.cpu_addr == bus.bp_addr) && armed_q;
`else
    logic unused_bus;
    assign bp_hit     = 1'b0;
    assign unused_bus = ^{bus.cpu_addr, armed_q};
`endif

    // Controller FSM with prescaler, reset-hold counter and registered outputs.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_HOLD;
            cpu_ce_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            halted_q    <= 1'b0;
            cnt_q       <= '0;
            hold_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            cpu_ce_q <= 1'b0;
            case (state_q)
                ST_RESET_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_q      <= '0;
                        cpu_rst_n_q <= 1'b1;
                        if (START_HALTED) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            cnt_q   <= div_sel;
                            armed_q <= 1'b0;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_HALT: begin
                    // Run wins over step when both arrive together.
                    if (run_ev) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                        cnt_q    <= div_sel;
                        armed_q  <= 1'b0;
                    end else if (step_ev) begin
                        state_q  <= ST_STEP;
                        halted_q <= 1'b0;
                        cpu_ce_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
                ST_RUN: begin
                    // A halt request swallows any CE due in the same cycle.
                    if (run_ev) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (cnt_q == '0) begin
                        cnt_q <= div_sel;
                        if (bp_hit) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            cpu_ce_q <= 1'b1;
                            armed_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_RESET_HOLD;
            endcase
        end
    end

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.cpu_rst_n = cpu_rst_n_q;
    assign bus.halted    = halted_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_scmp_clk_ctl.sv
// Self-checking bench for scmp_clk_ctl: randomized button stimulus, a queue
// of expected state transitions and a per-cycle clock-enable model.
module tb_scmp_clk_ctl;
    import scmp_clk_pkg::*;

    localparam int DIV_W   = 8;
    localparam int DB_W    = 2;
    localparam int RST_CYC = 4;

    logic             clk_50m    = 1'b0;
    logic             rst_n      = 1'b0;
    logic [DIV_W-1:0] div_sel    = 8'd3;
    logic             run_btn_n  = 1'b1;
    logic             step_btn_n = 1'b1;

    scmp_clk_if bus();

    scmp_clk_ctl #(
        .DIV_W        (DIV_W),
        .DB_W         (DB_W),
        .RST_CYC      (RST_CYC),
        .START_HALTED (1'b0)
    ) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .div_sel    (div_sel),
        .run_btn_n  (run_btn_n),
        .step_btn_n (step_btn_n),
        .bus        (bus)
    );

    always #5 clk_50m = ~clk_50m;

    int         n_checks = 0;
    int         n_fail   = 0;
    ctl_state_t exp_q[$];

    bit         mon_en   = 1'b0;
    bit         bp_mode  = 1'b0;
    ctl_state_t prev_st  = ST_RESET_HOLD;
    int         run_n    = 0;
    int         run_div  = 0;
    int         ce_total = 0;
    int         ce_run   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic set_btn(input bit r, input bit s, input logic lvl);
        if (r) run_btn_n = lvl;
        if (s) step_btn_n = lvl;
    endtask

    // Press with optional contact bounce on both edges, hold, then release.
    task automatic press(input bit r, input bit s, input int bounce);
        for (int i = 0; i < bounce; i++) begin
            set_btn(r, s, (i % 2 == 0) ? 1'b0 : 1'b1);
            tick();
        end
        set_btn(r, s, 1'b0);
        repeat (12) tick();
        for (int i = 0; i < bounce; i++) begin
            set_btn(r, s, (i % 2 == 0) ? 1'b1 : 1'b0);
            tick();
        end
        set_btn(r, s, 1'b1);
        repeat (12) tick();
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check("queue_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: state changes pop the scoreboard; CE is compared each cycle
    // against the rule "RUN entry + k*(div+1) cycles", "1 in STEP", "else 0".
    always @(negedge clk_50m) begin
        if (mon_en) begin
            ctl_state_t cur;
            bit         exp_ce;
            cur = bus.state;
            if (cur != prev_st) begin
                if (bp_mode && prev_st == ST_RUN && cur == ST_HALT)
                    check("bp_halt_on_due_ce", int'(((run_n + 1) % (run_div + 1)) == 0), 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_state: got %0d, expected no change from %0d at %0t",
                             cur, prev_st, $time);
                end else begin
                    check("state_seq", cur, exp_q.pop_front());
                end
                if (cur == ST_RUN) begin
                    run_n   = 0;
                    run_div = int'(div_sel);
                    ce_run  = 0;
                end
            end else if (cur == ST_RUN) begin
                run_n++;
            end
            exp_ce = (cur == ST_STEP) ||
                     (cur == ST_RUN && run_n > 0 && (run_n % (run_div + 1)) == 0);
            check("cpu_ce", bus.cpu_ce, exp_ce);
            check("halted", bus.halted, cur == ST_HALT);
            check("cpu_rst_n", bus.cpu_rst_n, cur != ST_RESET_HOLD);
            if (bus.cpu_ce) begin
                ce_total++;
                if (cur == ST_RUN) ce_run++;
            end
            prev_st = cur;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ce_before;
        bus.cpu_addr = 12'h000;
`ifdef SCMP_CLK_BREAK_EN
        bus.bp_en   = 1'b0;
        bus.bp_addr = 12'h000;
`endif
        // Reset state
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_state", bus.state, ST_RESET_HOLD);
        check("rst_ce", bus.cpu_ce, 0);
        check("rst_cpu_rst_n", bus.cpu_rst_n, 0);
        check("rst_halted", bus.halted, 0);

        // Release: cpu_rst_n after RST_CYC cycles, straight into RUN
        exp_q.push_back(ST_RUN);
        rst_n = 1'b1;
        cyc = 0;
        while (bus.cpu_rst_n == 1'b0 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("rst_hold_cycles", cyc, RST_CYC);
        repeat (20) tick();
        $display("INFO reset release into RUN, div_sel=3, CE count %0d", ce_run);
        check("run_div3_ce_count", int'(ce_run >= 4), 1);

        // Bounced run press -> one HALT, no CE afterwards
        exp_q.push_back(ST_HALT);
        press(1'b1, 1'b0, 2);
        wait_empty();
        ce_before = ce_total;
        repeat (20) tick();
        check("halt_no_ce", ce_total - ce_before, 0);
        $display("INFO bounced run press -> HALT");

        // Three single steps
        ce_before = ce_total;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(ST_STEP);
            exp_q.push_back(ST_HALT);
            press(1'b0, 1'b1, int'($urandom_range(0, 3)));
            wait_empty();
            $display("INFO step %0d done", k);
        end
        check("step_ce_count", ce_total - ce_before, 3);

        // div_sel = 0: CE every cycle
        div_sel = 8'd0;
        exp_q.push_back(ST_RUN);
        press(1'b1, 1'b0, 0);
        wait_empty();
        repeat (10) tick();
        exp_q.push_back(ST_HALT);
        press(1'b1, 1'b0, 1);
        wait_empty();
        $display("INFO div_sel=0 run done");

        // Randomized divider runs
        for (int k = 0; k < 4; k++) begin
            div_sel     = DIV_W'($urandom_range(0, 6));
            bus.cpu_addr = 12'($urandom);
            exp_q.push_back(ST_RUN);
            press(1'b1, 1'b0, int'($urandom_range(0, 3)));
            repeat ($urandom_range(5, 30)) tick();
            exp_q.push_back(ST_HALT);
            press(1'b1, 1'b0, int'($urandom_range(0, 3)));
            wait_empty();
            $display("INFO random run %0d div_sel=%0d", k, div_sel);
        end

        // Maximum divider: period 2**DIV_W
        div_sel = 8'hFF;
        exp_q.push_back(ST_RUN);
        press(1'b1, 1'b0, 0);
        repeat (540) tick();
        check("div_max_ce_count", ce_run, 2);
        exp_q.push_back(ST_HALT);
        press(1'b1, 1'b0, 0);
        wait_empty();
        $display("INFO div_sel=255 run done");

        // Run and step together in HALT -> RUN only
        div_sel = 8'd2;
        exp_q.push_back(ST_RUN);
        press(1'b1, 1'b1, 0);
        wait_empty();
        repeat (10) tick();
        exp_q.push_back(ST_HALT);
        press(1'b1, 1'b0, 0);
        wait_empty();
        $display("INFO simultaneous run+step -> RUN");

        // Reset in the middle of RUN
        exp_q.push_back(ST_RUN);
        press(1'b1, 1'b0, 0);
        wait_empty();
        repeat ($urandom_range(1, 7)) tick();
        exp_q.push_back(ST_RESET_HOLD);
        exp_q.push_back(ST_RUN);
        rst_n = 1'b0;
        tick();
        check("midrun_rst_state", bus.state, ST_RESET_HOLD);
        check("midrun_rst_ce", bus.cpu_ce, 0);
        check("midrun_rst_cpu_rst_n", bus.cpu_rst_n, 0);
        tick();
        rst_n = 1'b1;
        wait_empty();
        repeat (8) tick();
        exp_q.push_back(ST_HALT);
        press(1'b1, 1'b0, 0);
        wait_empty();
        $display("INFO mid-run reset done");

`ifdef SCMP_CLK_BREAK_EN
        // Breakpoint: first CE of a run is delivered, the next due CE halts
        div_sel      = 8'd3;
        bus.bp_addr  = 12'h123;
        bus.cpu_addr = 12'h123;
        bus.bp_en    = 1'b1;
        bp_mode      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(ST_RUN);
            exp_q.push_back(ST_HALT);
            press(1'b1, 1'b0, 0);
            wait_empty();
            check("bp_ce_before_halt", ce_run, 1);
            $display("INFO breakpoint pass %0d", k);
        end
        bp_mode   = 1'b0;
        bus.bp_en = 1'b0;
`endif

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
